// File: rtl/uart_rx_if.sv
// Bundle of the UART receive serial line, frame configuration and receive results.
// Result semantics: there is no ready. o_rx_data_valid, o_rx_par_err and
// o_rx_stop_err are single-cycle pulses. The consumer must take o_rx_data in
// the cycle o_rx_data_valid is high; o_rx_data then holds until the next good frame.
interface uart_rx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      i_rx_serial_in;
    logic [PRESCALE_WIDTH-1:0] i_rx_prescale;
    logic                      i_rx_par_en;
    logic                      i_rx_par_typ;
    logic [DATA_WIDTH-1:0]     o_rx_data;
    logic                      o_rx_data_valid;
    logic                      o_rx_par_err;
    logic                      o_rx_stop_err;
    logic                      o_rx_busy;
    logic [2:0]                o_rx_state;      // debug view of the receive FSM

    // master drives the line and configuration and observes the results
    modport master (
        output i_rx_serial_in, i_rx_prescale, i_rx_par_en, i_rx_par_typ,
        input  o_rx_data, o_rx_data_valid, o_rx_par_err, o_rx_stop_err,
        input  o_rx_busy, o_rx_state
    );

    // slave is the receiver itself
    modport slave (
        input  i_rx_serial_in, i_rx_prescale, i_rx_par_en, i_rx_par_typ,
        output o_rx_data, o_rx_data_valid, o_rx_par_err, o_rx_stop_err,
        output o_rx_busy, o_rx_state
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversamples the serial line with the system clock, majority-
// votes three mid-bit samples, and delivers each good frame as a parallel word
// with a one-cycle valid pulse. Parity and framing errors pulse separately.
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic      i_rx_clk,
    input logic      i_rx_rst_n,
    uart_rx_if.slave rx
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam int PW = PRESCALE_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  sync1;
    logic                  sin;
    logic [PW-1:0]         p_in;
    logic [PW-1:0]         p_eff;
    logic [PW-1:0]         p_cfg;
    logic [PW-1:0]         half;
    logic [PW-1:0]         edge_cnt;
    logic                  pen_cfg;
    logic                  ptyp_cfg;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [2:0]            smp;
    logic                  live;
    logic                  maj;
    logic                  bit_end;
    logic                  start_det;
    logic                  par_calc;
    logic                  par_fail;
    logic                  evt_valid;
    logic                  evt_par;
    logic                  evt_stop;
    logic                  pend_valid;
    logic                  pend_par;
    logic                  pend_stop;
    logic [DATA_WIDTH-1:0] data_pend;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  par_err_q;
    logic                  stop_err_q;

    // Bit 0 of the prescale is dropped (even P) and anything below 4 is raised to 4.
    assign p_in      = rx.i_rx_prescale & ~PW'(1);
    assign p_eff     = (p_in < PW'(4)) ? PW'(4) : p_in;
    assign half      = p_cfg >> 1;
    assign bit_end   = (edge_cnt == p_cfg - PW'(1));
    assign start_det = (state == IDLE) && !sin;
    assign par_calc  = (^shreg) ^ ptyp_cfg;

    // With P = 4 the third sample lands on the decision cycle, so it is taken live.
    assign live = (edge_cnt == half + PW'(1)) ? sin : smp[2];
    assign maj  = (smp[0] & smp[1]) | (smp[0] & live) | (smp[1] & live);

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge i_rx_clk) begin
        if (!i_rx_rst_n) begin
            sync1 <= 1'b1;
            sin   <= 1'b1;
        end else begin
            sync1 <= rx.i_rx_serial_in;
            sin   <= sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_rx_clk) begin
        if (!i_rx_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-bit decisions, all taken on the last clock of a bit.
    always_comb begin
        state_next = state;
        evt_valid  = 1'b0;
        evt_par    = 1'b0;
        evt_stop   = 1'b0;
        case (state)
            IDLE: begin
                if (!sin) state_next = START;
            end
            START: begin
                if (bit_end) state_next = maj ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) state_next = pen_cfg ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    evt_par    = (maj != par_calc);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    if (!maj) evt_stop = 1'b1;
                    else if (!par_fail) evt_valid = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timing counters, mid-bit samples, shift register and frame configuration.
    always_ff @(posedge i_rx_clk) begin
        if (!i_rx_rst_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            smp      <= 3'b111;
            p_cfg    <= PW'(4);
            pen_cfg  <= 1'b0;
            ptyp_cfg <= 1'b0;
            par_fail <= 1'b0;
        end else if (start_det) begin
            // The detection cycle is edge_cnt 0, so START begins at 1.
            edge_cnt <= PW'(1);
            bit_cnt  <= '0;
            p_cfg    <= p_eff;
            pen_cfg  <= rx.i_rx_par_en;
            ptyp_cfg <= rx.i_rx_par_typ;
            par_fail <= 1'b0;
        end else if (state != IDLE) begin
            edge_cnt <= bit_end ? '0 : edge_cnt + PW'(1);
            if (edge_cnt == half - PW'(1)) smp[0] <= sin;
            if (edge_cnt == half)          smp[1] <= sin;
            if (edge_cnt == half + PW'(1)) smp[2] <= sin;
            if ((state == DATA) && bit_end) begin
                shreg   <= (shreg >> 1) | (DATA_WIDTH'(maj) << (DATA_WIDTH - 1));
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
            end
            if (evt_par) par_fail <= 1'b1;
        end else begin
            edge_cnt <= '0;
        end
    end

    // Event pulses pass through one holding stage before the outputs, which
    // places them one cycle after the FSM is already back in IDLE.
    always_ff @(posedge i_rx_clk) begin
        if (!i_rx_rst_n) begin
            pend_valid <= 1'b0;
            pend_par   <= 1'b0;
            pend_stop  <= 1'b0;
            data_pend  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            pend_valid <= evt_valid;
            pend_par   <= evt_par;
            pend_stop  <= evt_stop;
            if (evt_valid) data_pend <= shreg;
            valid_q    <= pend_valid;
            par_err_q  <= pend_par;
            stop_err_q <= pend_stop;
            if (pend_valid) data_q <= data_pend;
        end
    end

    assign rx.o_rx_data       = data_q;
    assign rx.o_rx_data_valid = valid_q;
    assign rx.o_rx_par_err    = par_err_q;
    assign rx.o_rx_stop_err   = stop_err_q;
    assign rx.o_rx_busy       = (state != IDLE) || pend_valid || pend_stop;
    assign rx.o_rx_state      = state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, expected pulses queued by the driver and
// checked by an independent monitor on the falling clock edge.
module tb_uart_rx;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int EW = 32 + DW + 2;   // {cycle, data, kind}
    localparam logic [1:0] K_VALID = 2'd1;
    localparam logic [1:0] K_PAR   = 2'd2;
    localparam logic [1:0] K_STOP  = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] last_good = '0;
    logic [EW-1:0] exp_q[$];

    uart_rx_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) rx_if();

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .i_rx_clk   (clk),
        .i_rx_rst_n (rst_n),
        .rx         (rx_if.slave)
    );

    // clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_event(input logic [1:0] kind);
        logic [EW-1:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: kind=%0d data=%h cycle=%0d, required no pulse",
                     kind, rx_if.o_rx_data, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e[1:0] != kind || e[DW+1:2] != rx_if.o_rx_data || e[EW-1:DW+2] != 32'(cyc)) begin
            miscompares++;
            $display("FAIL pulse: got kind=%0d data=%h cycle=%0d, required kind=%0d data=%h cycle=%0d",
                     kind, rx_if.o_rx_data, cyc, e[1:0], e[DW+1:2], e[EW-1:DW+2]);
        end
    endtask

    // monitor: every output pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_if.o_rx_data_valid) check_event(K_VALID);
            if (rx_if.o_rx_par_err)    check_event(K_PAR);
            if (rx_if.o_rx_stop_err)   check_event(K_STOP);
        end
    end

    // hold the line at b for p clocks; returns just after a rising edge
    task automatic drive_bit(input logic b, input int p);
        rx_if.i_rx_serial_in = b;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                              input logic ptyp, input logic pbit, input logic stopb);
        int c0;
        int f;
        logic par_ok;
        rx_if.i_rx_prescale = PW'(p);
        rx_if.i_rx_par_en   = pen;
        rx_if.i_rx_par_typ  = ptyp;
        c0 = cyc + 1;                       // edge at which the start bit is first sampled
        f = 1 + DW + (pen ? 1 : 0) + 1;
        par_ok = !pen || (pbit == ((^d) ^ ptyp));
        if (!par_ok) exp_q.push_back({32'(c0 + 2 + (DW + 2) * p), last_good, K_PAR});
        if (!stopb) begin
            exp_q.push_back({32'(c0 + 2 + f * p), last_good, K_STOP});
        end else if (par_ok) begin
            exp_q.push_back({32'(c0 + 2 + f * p), d, K_VALID});
            last_good = d;
        end
        drive_bit(1'b0, p);
        for (int i = 0; i < DW; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stopb, p);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"},     int'(rx_if.o_rx_busy), 0);
        check_val({tag, "_state"},    int'(rx_if.o_rx_state), 0);
        check_val({tag, "_data"},     int'(rx_if.o_rx_data), 0);
        check_val({tag, "_valid"},    int'(rx_if.o_rx_data_valid), 0);
        check_val({tag, "_par_err"},  int'(rx_if.o_rx_par_err), 0);
        check_val({tag, "_stop_err"}, int'(rx_if.o_rx_stop_err), 0);
    endtask

    // watchdog
    initial begin
        #200000;
        miscompares++;
        $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        rx_if.i_rx_serial_in = 1'b1;
        rx_if.i_rx_prescale  = PW'(8);
        rx_if.i_rx_par_en    = 1'b0;
        rx_if.i_rx_par_typ   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        drive_bit(1'b1, 4);

        // clean 8N1 frame, P = 8: valid 82 cycles after the start is sampled
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 8);

        // even parity good, even parity bad (data held), odd parity good
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 4);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b1, 4);
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 4);

        // framing error: stop bit low, previous data held
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 20);

        // start glitch: 3 low cycles, P = 16
        rx_if.i_rx_prescale = PW'(16);
        rx_if.i_rx_par_en   = 1'b0;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 4);
        check_val("glitch_busy_mid", int'(rx_if.o_rx_busy), 1);
        check_val("glitch_state_mid", int'(rx_if.o_rx_state), 1);
        drive_bit(1'b1, 16);
        check_val("glitch_busy_after", int'(rx_if.o_rx_busy), 0);
        check_val("glitch_state_after", int'(rx_if.o_rx_state), 0);

        // back-to-back, no idle gap: pulses 10*P apart
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 10);

        // reset during DATA, then a full frame
        rx_if.i_rx_prescale = PW'(8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 4);
        check_val("pre_reset_busy", int'(rx_if.o_rx_busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("midreset");
        rst_n = 1'b1;
        last_good = '0;
        drive_bit(1'b1, 20);
        check_val("post_reset_busy", int'(rx_if.o_rx_busy), 0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 10);

        // any expected pulse that never appeared
        while (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse: got none, required kind=%0d data=%h cycle=%0d",
                     e[1:0], e[DW+1:2], e[EW-1:DW+2]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: the receive-side counterpart of the TX-only datapath, sharing its frame format (start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity, one stop bit). It oversamples the asynchronous serial line with the system clock and majority-votes each bit at mid-bit. Each good frame is delivered as a parallel word with a one-cycle valid pulse. Parity and framing errors are flagged with one-cycle pulses.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_WIDTH, 6, width of the clocks-per-bit input

Ports:
- i_rx_clk  input  1  system clock; oversampling clock
- i_rx_rst_n  input  1  reset; synchronous and active-low
- i_rx_serial_in  input  1  asynchronous serial line; idle high
- i_rx_prescale  input  PRESCALE_WIDTH  clocks per bit (P); bit 0 ignored (forced even); values below 4 treated as 4
- i_rx_par_en  input  1  1 = parity bit present
- i_rx_par_typ  input  1  0 = even parity, 1 = odd parity
- o_rx_data  output  DATA_WIDTH  last good received word; reset 0
- o_rx_data_valid  output  1  one-cycle pulse when o_rx_data updates; reset 0
- o_rx_par_err  output  1  one-cycle pulse on parity mismatch; reset 0
- o_rx_stop_err  output  1  one-cycle pulse when stop bit is sampled 0; reset 0
- o_rx_busy  output  1  high in any state other than IDLE; reset 0

## Operation
- Input path: 2-flop synchronizer on i_rx_serial_in, reset to 1. All decisions use the synchronized value (sin).
- Configuration capture: P, par_en and par_typ are latched on start detection. Changes mid-frame are ignored.
- Counters:
  - edge_cnt runs 0..P-1 within each bit.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
- Sampling: sin is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three and is used at edge_cnt = P-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when sin = 0, go to START. The detection cycle counts as edge_cnt 0.
  - START: at P-1, if the majority is 1 (glitch), go to IDLE with no output pulse. Otherwise go to DATA with bit_cnt = 0.
  - DATA: at P-1, shift the majority into the shift register (LSB first) and increment bit_cnt. After bit DATA_WIDTH-1, go to PARITY if par_en, else STOP.
  - PARITY: at P-1, compare the majority with the computed parity: XOR of data, inverted if par_typ = 1. On mismatch, set the internal par_fail flag and pulse o_rx_par_err. Go to STOP.
  - STOP: at P-1, go to IDLE. Then:
    - If the majority is 0: pulse o_rx_stop_err; do not update data.
    - Else if par_fail is clear: load o_rx_data from the shift register and pulse o_rx_data_valid.
- A failed frame never updates o_rx_data; the previous value is held.
- Back-to-back frames: IDLE checks sin on its first cycle, so the next start bit is detected with no lost cycle.
- Reset asserted mid-frame: the FSM goes to IDLE and all outputs and flags clear on that edge. Only a fresh falling edge after reset starts a new frame.

## Timing
- Latency: let cycle 0 be the clock edge at which the pin is first sampled low. START is entered at cycle 2.
- With F = 1 + DATA_WIDTH + par_en + 1 bits per frame, the output pulse (valid or stop_err) is high during cycle 2 + F·P, for exactly 1 cycle.
  - Example: 8N1, P = 16 gives cycle 162.
- o_rx_par_err is high during cycle 2 + (1 + DATA_WIDTH + 1)·P, i.e. the cycle after the parity bit ends.
- o_rx_busy rises at cycle 2. It falls in the cycle the final pulse is asserted.
- Outputs are registered, with no combinational path from the inputs.
- Timing tolerance: mid-bit sampling tolerates ±(P/2 − 2) clocks of cumulative drift per frame.

## Test plan
- Clean frame: P = 8, 8N1, send 0xA5. Require o_rx_data = 0xA5, a valid pulse at cycle 82, and no errors.
- Even parity: P = 16, par_en = 1, par_typ = 0, send 0x3C with parity bit 0. Require a valid pulse with data 0x3C. Then send 0x3C with parity bit 1. Require an o_rx_par_err pulse, no valid pulse, and data held at 0x3C.
- Framing error: send 0x81 with the stop bit driven 0. Require an o_rx_stop_err pulse at the stop bit end, no valid pulse, and the previous data held.
- Start glitch: P = 16, drive the line low for 3 cycles in idle. Require a return to IDLE by the end of the start bit, with no pulses and busy low afterwards.
- Back-to-back: send 0x00 then 0xFF with no idle gap between stop and start. Require two valid pulses exactly 10·P cycles apart, with the correct data on each.
- Reset mid-frame: assert i_rx_rst_n = 0 for 1 cycle during DATA. Require busy = 0 and all outputs 0. Then require a correct reception of the next full frame, 0x5A.
